// File: rtl/conv_mode_scheduler.sv
// Mode scheduler for the convolution buffer: arbitrates mode-change requests and applies them at frame boundaries.
// Optional macro CONV_SCHED_RR_EN selects round-robin arbitration instead of fixed host priority.
module conv_mode_scheduler #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sw_req,
  input  logic [1:0] sw_mode,
  input  logic       host_req,
  input  logic [1:0] host_mode,
  output logic       sw_gnt,
  output logic       host_gnt,
  input  logic       pix_valid,
  output logic [1:0] mode_out,
  output logic       pend,
  output logic [9:0] col,
  output logic [8:0] row,
  output logic       frame_start
);

  typedef enum logic {IDLE, PENDING} state_t;

  state_t     state;
  logic [1:0] pend_mode;
  logic       col_last;
  logic       row_last;
  logic       frame_end;
  logic       sw_elig;
  logic       host_elig;
  logic       grant_sw;
  logic       grant_host;
  logic       accept;
  logic [1:0] accept_mode;

  assign col_last  = (col == 10'(H_ACTIVE - 1));
  assign row_last  = (row == 9'(V_ACTIVE - 1));
  assign frame_end = pix_valid & col_last & row_last;

  // A requester whose grant is showing this cycle still holds its request; masking it avoids a double grant.
  assign sw_elig   = sw_req & ~sw_gnt;
  assign host_elig = host_req & ~host_gnt;

`ifdef CONV_SCHED_RR_EN
  logic last_host;

  always_comb begin
    grant_sw   = sw_elig & (~host_elig | last_host);
    grant_host = host_elig & (~sw_elig | ~last_host);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_host <= 1'b1;
    end else if (grant_sw) begin
      last_host <= 1'b0;
    end else if (grant_host) begin
      last_host <= 1'b1;
    end
  end
`else
  always_comb begin
    grant_host = host_elig;
    grant_sw   = sw_elig & ~host_elig;
  end
`endif

  assign accept      = grant_sw | grant_host;
  assign accept_mode = grant_host ? host_mode : sw_mode;
  assign pend        = (state == PENDING);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (pix_valid) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + 9'd1;
      end else begin
        col <= col + 10'd1;
      end
    end
  end

  // On a frame_end that coincides with a new accept, mode_out takes the older pend_mode before it is overwritten.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pend_mode   <= 2'b00;
      mode_out    <= 2'b00;
      sw_gnt      <= 1'b0;
      host_gnt    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      sw_gnt      <= grant_sw;
      host_gnt    <= grant_host;
      frame_start <= frame_end;
      if (frame_end && state == PENDING) begin
        mode_out <= pend_mode;
      end
      if (accept) begin
        pend_mode <= accept_mode;
        state     <= PENDING;
      end else if (frame_end) begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_conv_mode_scheduler.sv
// Scoreboard bench for conv_mode_scheduler on a reduced 16x8 frame; reference model works on a flat pixel index.
module tb_conv_mode_scheduler;

  localparam int H = 16;
  localparam int V = 8;
  localparam int F = H * V;
`ifdef CONV_SCHED_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       sw_req;
  logic [1:0] sw_mode;
  logic       host_req;
  logic [1:0] host_mode;
  logic       sw_gnt;
  logic       host_gnt;
  logic       pix_valid;
  logic [1:0] mode_out;
  logic       pend;
  logic [9:0] col;
  logic [8:0] row;
  logic       frame_start;

  int checks = 0;
  int errors = 0;

  conv_mode_scheduler #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .clk(clk), .rst(rst),
    .sw_req(sw_req), .sw_mode(sw_mode),
    .host_req(host_req), .host_mode(host_mode),
    .sw_gnt(sw_gnt), .host_gnt(host_gnt),
    .pix_valid(pix_valid), .mode_out(mode_out), .pend(pend),
    .col(col), .row(row), .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Reference model: flat pixel index within the frame plus an abstract pending-mode record.
  int gntQ[$];
  int frameQ[$];
  int pixIdx, expMode, expPend, pendModeM, expCol, expRow;
  bit swPrev, hostPrev, lastHost;
  int winner;
  bit swE, hostE, fe;

  always @(posedge clk) begin
    if (rst) begin
      pixIdx = 0; expMode = 0; expPend = 0; pendModeM = 0;
      swPrev = 0; hostPrev = 0; lastHost = 1;
    end else begin
      fe    = pix_valid && (pixIdx == F - 1);
      swE   = sw_req && !swPrev;
      hostE = host_req && !hostPrev;
      winner = 0;
      if (swE && hostE) winner = RR ? (lastHost ? 1 : 2) : 2;
      else if (swE) winner = 1;
      else if (hostE) winner = 2;
      if (fe && expPend != 0) expMode = pendModeM;
      if (winner != 0) begin
        pendModeM = (winner == 1) ? int'(sw_mode) : int'(host_mode);
        expPend = 1;
        lastHost = (winner == 2);
      end else if (fe) begin
        expPend = 0;
      end
      if (winner == 1) gntQ.push_back(2);
      else if (winner == 2) gntQ.push_back(1);
      swPrev = (winner == 1);
      hostPrev = (winner == 2);
      if (fe) frameQ.push_back(expMode);
      if (pix_valid) pixIdx = (pixIdx + 1) % F;
    end
    expCol = pixIdx % H;
    expRow = pixIdx / H;
  end

  // Monitor: per-cycle state comparison plus queue pops whenever a grant or frame_start appears.
  always @(posedge clk) begin
    #1;
    checkOutput("col", int'(col), expCol);
    checkOutput("row", int'(row), expRow);
    checkOutput("mode_out", int'(mode_out), expMode);
    checkOutput("pend", int'(pend), expPend);
    if (gntQ.size() != 0) checkOutput("gnt", int'({sw_gnt, host_gnt}), gntQ.pop_front());
    else if (sw_gnt || host_gnt) checkOutput("gnt", int'({sw_gnt, host_gnt}), 0);
    if (frameQ.size() != 0) begin
      checkOutput("frame_start", int'(frame_start), 1);
      checkOutput("frame_mode", int'(mode_out), frameQ.pop_front());
    end else if (frame_start) begin
      checkOutput("frame_start", int'(frame_start), 0);
    end
  end

  bit swDrop, hostDrop;

  task automatic applyStimulus(input bit pv, input bit randReq);
    @(negedge clk);
    if (swDrop) begin sw_req = 1'b0; swDrop = 1'b0; end
    else if (sw_gnt) swDrop = 1'b1;
    if (hostDrop) begin host_req = 1'b0; hostDrop = 1'b0; end
    else if (host_gnt) hostDrop = 1'b1;
    if (randReq) begin
      if (!sw_req && !swDrop && $urandom_range(0, 15) == 0) begin
        sw_mode = 2'($urandom);
        sw_req = 1'b1;
      end
      if (!host_req && !hostDrop && $urandom_range(0, 15) == 0) begin
        host_mode = 2'($urandom);
        host_req = 1'b1;
      end
    end
    pix_valid = pv;
  endtask

  task automatic doReset();
    rst = 1'b1;
    sw_req = 1'b0; host_req = 1'b0; pix_valid = 1'b0;
    swDrop = 1'b0; hostDrop = 1'b0;
    repeat (3) applyStimulus(1'b0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; sw_req = 1'b0; host_req = 1'b0; sw_mode = 2'b00; host_mode = 2'b00;
    pix_valid = 1'b0; swDrop = 1'b0; hostDrop = 1'b0;
    doReset();

    $display("[TB] single switch request over one frame");
    sw_mode = 2'b01; sw_req = 1'b1;
    repeat (F) applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("single_mode", int'(mode_out), 1);
    checkOutput("single_fs", int'(frame_start), 1);
    checkOutput("single_pend", int'(pend), 0);

    $display("[TB] simultaneous requests");
    doReset();
    sw_mode = 2'b10; host_mode = 2'b11; sw_req = 1'b1; host_req = 1'b1;
    repeat (F) applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("tie_mode", int'(mode_out), RR ? 3 : 2);

    $display("[TB] request coinciding with frame end");
    doReset();
    sw_mode = 2'b01; sw_req = 1'b1;
    repeat (F) applyStimulus(1'b1, 1'b0);
    host_mode = 2'b11; host_req = 1'b1;
    applyStimulus(1'b0, 1'b0);
    checkOutput("fe_req_mode", int'(mode_out), 1);
    checkOutput("fe_req_pend", int'(pend), 1);
    repeat (F) applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("fe_req_next_mode", int'(mode_out), 3);

    $display("[TB] strobe gap after one row");
    doReset();
    repeat (H) applyStimulus(1'b1, 1'b0);
    repeat (5) applyStimulus(1'b0, 1'b0);
    checkOutput("gap_col", int'(col), 0);
    checkOutput("gap_row", int'(row), 1);
    checkOutput("gap_fs", int'(frame_start), 0);

    $display("[TB] reset mid-frame with a pending mode");
    doReset();
    sw_mode = 2'b10; sw_req = 1'b1;
    repeat (3 * H + 5) applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("pre_rst_pend", int'(pend), 1);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0);
    checkOutput("rst_pend", int'(pend), 0);
    checkOutput("rst_mode", int'(mode_out), 0);
    checkOutput("rst_col", int'(col), 0);
    checkOutput("rst_row", int'(row), 0);
    rst = 1'b0;

    $display("[TB] randomized traffic");
    repeat (3000) begin
      if ($urandom_range(0, 599) == 0) begin
        rst = 1'b1;
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1);
        rst = 1'b0;
      end else begin
        applyStimulus($urandom_range(0, 3) != 0, 1'b1);
      end
    end
    repeat (4) applyStimulus(1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
